// File: rtl/arb_req_pkg.sv
// Shared types and helpers for the arbiter requester agent (arb_req_agent).
package arb_req_pkg;

    localparam int N_REQ = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        XFER = 2'd2
    } client_state_e;

    typedef logic [1:0] client_id_t;

    function automatic client_id_t onehot_enc(input logic [N_REQ-1:0] oh);
        client_id_t idx;
        idx = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (oh[i]) idx = client_id_t'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/arb_req_client.sv
// One requester lane: IDLE/WAIT/XFER FSM, remaining-beat counter, request logic and
// the optional starvation counter (built only with ARB_REQ_STARVE_MON_EN defined).
module arb_req_client
    import arb_req_pkg::*;
#(
    parameter int LEN_W        = 4,
    parameter int STARVE_LIMIT = 64,
    parameter int STARVE_W     = 7
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              job_valid,
    input  logic [LEN_W-1:0]  job_len,
    input  logic              gnt,
    input  logic              gnt_ok,
    output logic              job_ready,
    output logic              req,
    output logic              beat,
    output logic              last,
    output logic              done,
    output logic              starve,
    output client_state_e     state
);

    localparam logic [LEN_W:0] REM_ONE = (LEN_W+1)'(1);

    client_state_e  state_n;
    logic [LEN_W:0] rem, rem_n;
    logic           busy;
    logic           grant;

    assign busy  = (state != IDLE);
    // A grant inside an illegal multi-hot vector is not honoured at all.
    assign grant = gnt & gnt_ok & busy;
    assign last  = (rem == REM_ONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            rem   <= '0;
        end else begin
            state <= state_n;
            rem   <= rem_n;
        end
    end

    always_comb begin
        state_n = state;
        rem_n   = rem;
        case (state)
            IDLE: begin
                if (job_valid) begin
                    rem_n   = {1'b0, job_len} + REM_ONE;
                    state_n = WAIT;
                end
            end
            WAIT, XFER: begin
                if (grant) begin
                    rem_n   = rem - REM_ONE;
                    state_n = last ? IDLE : XFER;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign job_ready = (state == IDLE);
    // Dropping req in the last-beat cycle keeps the registered arbiter from granting again.
    assign req  = busy & ~(gnt & gnt_ok & last);
    assign beat = grant;
    assign done = grant & last;

`ifdef ARB_REQ_STARVE_MON_EN
    localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(STARVE_LIMIT);
    localparam logic [STARVE_W-1:0] CNT_ONE    = STARVE_W'(1);

    logic [STARVE_W-1:0] starve_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve_cnt <= '0;
        end else if (!busy || grant) begin
            starve_cnt <= '0;
        end else if (!gnt && starve_cnt != STARVE_MAX) begin
            starve_cnt <= starve_cnt + CNT_ONE;
        end
    end

    assign starve = (starve_cnt == STARVE_MAX);
`else
    localparam bit LIMIT_FITS = (STARVE_LIMIT <= (1 << STARVE_W) - 1);

    // Monitor not built: flag is held low.
    assign starve = 1'b0 & LIMIT_FITS;
`endif

endmodule

// File: rtl/arb_req_agent.sv
// Requester-side front end for the 4-way arbiter: per-client burst lanes, beat mux and
// sticky grant-protocol error flags. Optional starvation monitor: ARB_REQ_STARVE_MON_EN.
module arb_req_agent
    import arb_req_pkg::*;
#(
    parameter int LEN_W        = 4,
    parameter int STARVE_LIMIT = 64,
    parameter int STARVE_W     = 7
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_REQ-1:0]       job_valid,
    input  logic [N_REQ*LEN_W-1:0] job_len,
    output logic [N_REQ-1:0]       job_ready,
    output logic [N_REQ-1:0]       req,
    input  logic [N_REQ-1:0]       gnt,
    output logic                   beat_valid,
    output client_id_t             beat_id,
    output logic                   beat_last,
    output logic [N_REQ-1:0]       done,
    output logic                   err_onehot,
    output logic                   err_unreq,
    output logic [N_REQ-1:0]       starve
);

    // Handshake: a job is taken on any edge where job_valid[i] && job_ready[i];
    // the grant is a one-cycle strobe and each honoured grant moves exactly one beat.

    client_state_e    client_state [N_REQ];
    logic [N_REQ-1:0] busy;
    logic [N_REQ-1:0] beat_vec;
    logic [N_REQ-1:0] last_vec;
    logic             gnt_ok;

    assign gnt_ok = ((gnt & (gnt - N_REQ'(1))) == '0);

    for (genvar g = 0; g < N_REQ; g++) begin : g_client
        arb_req_client #(
            .LEN_W        (LEN_W),
            .STARVE_LIMIT (STARVE_LIMIT),
            .STARVE_W     (STARVE_W)
        ) u_client (
            .clk       (clk),
            .rst       (rst),
            .job_valid (job_valid[g]),
            .job_len   (job_len[g*LEN_W +: LEN_W]),
            .gnt       (gnt[g]),
            .gnt_ok    (gnt_ok),
            .job_ready (job_ready[g]),
            .req       (req[g]),
            .beat      (beat_vec[g]),
            .last      (last_vec[g]),
            .done      (done[g]),
            .starve    (starve[g]),
            .state     (client_state[g])
        );

        assign busy[g] = (client_state[g] != IDLE);
    end

    assign beat_valid = |beat_vec;
    assign beat_id    = onehot_enc(beat_vec);
    assign beat_last  = |(beat_vec & last_vec);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_onehot <= 1'b0;
            err_unreq  <= 1'b0;
        end else begin
            if (!gnt_ok)           err_onehot <= 1'b1;
            if (|(gnt & ~busy))    err_unreq  <= 1'b1;
        end
    end

endmodule

// File: tb/tb_arb_req_agent.sv
// Directed bench for arb_req_agent with a behavioural registered arbiter model.
module tb_arb_req_agent;
    import arb_req_pkg::*;

    typedef enum int {M_FORCE, M_P0, M_P3, M_RR} arb_mode_e;

    logic        clk;
    logic        rst;
    logic [3:0]  job_valid;
    logic [15:0] job_len;
    logic [3:0]  job_ready;
    logic [3:0]  req;
    logic [3:0]  gnt;
    logic        beat_valid;
    client_id_t  beat_id;
    logic        beat_last;
    logic [3:0]  done;
    logic        err_onehot;
    logic        err_unreq;
    logic [3:0]  starve;

    arb_mode_e   arb_mode;
    logic [3:0]  gnt_force;
    logic [1:0]  rr_ptr;

    int checks;
    int errors;

    arb_req_agent #(
        .LEN_W        (4),
        .STARVE_LIMIT (8),
        .STARVE_W     (7)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .job_valid  (job_valid),
        .job_len    (job_len),
        .job_ready  (job_ready),
        .req        (req),
        .gnt        (gnt),
        .beat_valid (beat_valid),
        .beat_id    (beat_id),
        .beat_last  (beat_last),
        .done       (done),
        .err_onehot (err_onehot),
        .err_unreq  (err_unreq),
        .starve     (starve)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- arbiter model ----------------
    function automatic logic [3:0] pick_hi(input logic [3:0] r);
        logic [3:0] g;
        g = '0;
        for (int i = 0; i < 4; i++) if (r[i]) g = 4'b0001 << i;
        return g;
    endfunction

    function automatic logic [3:0] pick_rr(input logic [3:0] r, input logic [1:0] p);
        logic [3:0] g;
        logic [1:0] k;
        g = '0;
        for (int i = 3; i >= 0; i--) begin
            k = p + 2'(i);
            if (r[k]) g = 4'b0001 << k;
        end
        return g;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gnt    <= '0;
            rr_ptr <= '0;
        end else begin
            case (arb_mode)
                M_FORCE: gnt <= gnt_force;
                M_P0:    gnt <= req & (~req + 4'd1);
                M_P3:    gnt <= pick_hi(req);
                default: begin
                    gnt <= pick_rr(req, rr_ptr);
                    if (|req) rr_ptr <= onehot_enc(pick_rr(req, rr_ptr)) + 2'd1;
                end
            endcase
        end
    end

    // ---------------- driver ----------------
    // Drives job inputs and the forced grant for the next edge, then lands on the
    // following negedge so the caller samples the new cycle.
    task automatic step(input logic [3:0] jv, input logic [15:0] jl, input logic [3:0] gf);
        job_valid = jv;
        job_len   = jl;
        gnt_force = gf;
        @(posedge clk);
        #1;
        job_valid = '0;
        @(negedge clk);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checks++; if (req !== 4'h0)       begin errors++; $display("FAIL rst_req got %b exp 0000", req); end
        checks++; if (job_ready !== 4'hF) begin errors++; $display("FAIL rst_job_ready got %b exp 1111", job_ready); end
        checks++; if (beat_valid !== 1'b0 || beat_last !== 1'b0) begin errors++; $display("FAIL rst_beat got %b%b exp 00", beat_valid, beat_last); end
        checks++; if (done !== 4'h0)      begin errors++; $display("FAIL rst_done got %b exp 0000", done); end
        checks++; if (err_onehot !== 1'b0 || err_unreq !== 1'b0) begin errors++; $display("FAIL rst_err got %b%b exp 00", err_onehot, err_unreq); end
        checks++; if (starve !== 4'h0)    begin errors++; $display("FAIL rst_starve got %b exp 0000", starve); end
        rst = 1'b0;
    endtask

    task automatic test_p0_burst();
        logic [3:0] e_req  [1:7];
        logic [3:0] e_gnt  [1:7];
        logic [3:0] e_done [1:7];
        logic       e_bv   [1:7];
        logic [1:0] e_bid  [1:7];
        logic       e_bl   [1:7];
        e_req  = '{4'b0011, 4'b0011, 4'b0011, 4'b0010, 4'b0010, 4'b0000, 4'b0000};
        e_gnt  = '{4'b0000, 4'b0001, 4'b0001, 4'b0001, 4'b0010, 4'b0010, 4'b0000};
        e_done = '{4'b0000, 4'b0000, 4'b0000, 4'b0001, 4'b0000, 4'b0010, 4'b0000};
        e_bv   = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        e_bid  = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd0};
        e_bl   = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        arb_mode = M_P0;
        for (int c = 1; c <= 7; c++) begin
            if (c == 1) step(4'b0011, 16'h0012, 4'h0);
            else        step(4'b0000, 16'h0000, 4'h0);
            checks++; if (req !== e_req[c])   begin errors++; $display("FAIL p0_req c%0d got %b exp %b", c, req, e_req[c]); end
            checks++; if (gnt !== e_gnt[c])   begin errors++; $display("FAIL p0_gnt c%0d got %b exp %b", c, gnt, e_gnt[c]); end
            checks++; if (done !== e_done[c]) begin errors++; $display("FAIL p0_done c%0d got %b exp %b", c, done, e_done[c]); end
            checks++; if (beat_valid !== e_bv[c]) begin errors++; $display("FAIL p0_beat_valid c%0d got %b exp %b", c, beat_valid, e_bv[c]); end
            checks++; if (beat_last !== e_bl[c])  begin errors++; $display("FAIL p0_beat_last c%0d got %b exp %b", c, beat_last, e_bl[c]); end
            if (e_bv[c]) begin
                checks++; if (beat_id !== e_bid[c]) begin errors++; $display("FAIL p0_beat_id c%0d got %0d exp %0d", c, beat_id, e_bid[c]); end
            end
        end
    endtask

    task automatic test_rr_single();
        int         nbeats;
        logic [3:0] seen;
        nbeats = 0;
        seen   = '0;
        arb_mode = M_RR;
        for (int c = 1; c <= 7; c++) begin
            if (c == 1) step(4'b1111, 16'h0000, 4'h0);
            else        step(4'b0000, 16'h0000, 4'h0);
            if (c == 1) begin
                checks++; if (req !== 4'b1111) begin errors++; $display("FAIL rr_req_c1 got %b exp 1111", req); end
            end
            if (beat_valid) begin
                nbeats++;
                seen[beat_id] = 1'b1;
                checks++; if (beat_last !== 1'b1) begin errors++; $display("FAIL rr_beat_last c%0d got %b exp 1", c, beat_last); end
                checks++; if (done !== (4'b0001 << beat_id)) begin errors++; $display("FAIL rr_done c%0d got %b exp %b", c, done, 4'b0001 << beat_id); end
            end
            if (c == 6) begin
                checks++; if (req !== 4'b0000) begin errors++; $display("FAIL rr_req_idle got %b exp 0000", req); end
            end
        end
        checks++; if (nbeats != 4)     begin errors++; $display("FAIL rr_beat_count got %0d exp 4", nbeats); end
        checks++; if (seen !== 4'hF)   begin errors++; $display("FAIL rr_ids got %b exp 1111", seen); end
    endtask

    task automatic test_preempt();
        logic [3:0] e_req  [1:7];
        logic [3:0] e_gnt  [1:7];
        logic [3:0] e_done [1:7];
        logic [1:0] e_bid  [1:7];
        e_req  = '{4'b0100, 4'b0100, 4'b1100, 4'b0100, 4'b0100, 4'b0000, 4'b0000};
        e_gnt  = '{4'b0000, 4'b0100, 4'b0100, 4'b1000, 4'b0100, 4'b0100, 4'b0000};
        e_done = '{4'b0000, 4'b0000, 4'b0000, 4'b1000, 4'b0000, 4'b0100, 4'b0000};
        e_bid  = '{2'd0, 2'd2, 2'd2, 2'd3, 2'd2, 2'd2, 2'd0};
        arb_mode = M_P3;
        for (int c = 1; c <= 7; c++) begin
            if (c == 1)      step(4'b0100, 16'h0300, 4'h0);
            else if (c == 3) step(4'b1000, 16'h0000, 4'h0);
            else             step(4'b0000, 16'h0000, 4'h0);
            checks++; if (req !== e_req[c])   begin errors++; $display("FAIL pre_req c%0d got %b exp %b", c, req, e_req[c]); end
            checks++; if (gnt !== e_gnt[c])   begin errors++; $display("FAIL pre_gnt c%0d got %b exp %b", c, gnt, e_gnt[c]); end
            checks++; if (done !== e_done[c]) begin errors++; $display("FAIL pre_done c%0d got %b exp %b", c, done, e_done[c]); end
            if (e_gnt[c] != 4'h0) begin
                checks++; if (beat_valid !== 1'b1 || beat_id !== e_bid[c]) begin errors++; $display("FAIL pre_beat c%0d got %b/%0d exp 1/%0d", c, beat_valid, beat_id, e_bid[c]); end
            end
        end
    endtask

    task automatic test_starve();
        logic e_st;
        arb_mode  = M_FORCE;
        gnt_force = 4'h0;
        for (int c = 1; c <= 11; c++) begin
            if (c == 1)       step(4'b0010, 16'h0000, 4'h0);
            else if (c == 10) step(4'b0000, 16'h0000, 4'b0010);
            else              step(4'b0000, 16'h0000, 4'h0);
`ifdef ARB_REQ_STARVE_MON_EN
            e_st = (c == 9) || (c == 10);
`else
            e_st = 1'b0;
`endif
            checks++; if (starve !== {2'b00, e_st, 1'b0}) begin errors++; $display("FAIL starve c%0d got %b exp %b", c, starve, {2'b00, e_st, 1'b0}); end
            if (c <= 9) begin
                checks++; if (req !== 4'b0010 || beat_valid !== 1'b0) begin errors++; $display("FAIL starve_hold c%0d got req %b bv %b exp 0010/0", c, req, beat_valid); end
            end
            if (c == 10) begin
                checks++; if (done !== 4'b0010) begin errors++; $display("FAIL starve_done got %b exp 0010", done); end
            end
        end
        checks++; if (req !== 4'h0) begin errors++; $display("FAIL starve_req_end got %b exp 0000", req); end
    endtask

    task automatic test_errors();
        logic [3:0] gf;
        arb_mode = M_FORCE;
        for (int c = 1; c <= 8; c++) begin
            if (c == 2)                gf = 4'b0101;
            else if (c >= 3 && c <= 6) gf = 4'b0001;
            else if (c == 7)           gf = 4'b1000;
            else                       gf = 4'b0000;
            if (c == 1) step(4'b0101, 16'h0303, gf);
            else        step(4'b0000, 16'h0000, gf);
            if (c == 2) begin
                checks++; if (beat_valid !== 1'b0 || done !== 4'h0) begin errors++; $display("FAIL err_no_beat got bv %b done %b exp 0/0000", beat_valid, done); end
                checks++; if (req !== 4'b0101) begin errors++; $display("FAIL err_req_hold got %b exp 0101", req); end
            end
            if (c >= 3) begin
                checks++; if (err_onehot !== 1'b1) begin errors++; $display("FAIL err_onehot c%0d got %b exp 1", c, err_onehot); end
            end
            if (c >= 3 && c <= 6) begin
                checks++; if (beat_valid !== 1'b1 || beat_id !== 2'd0) begin errors++; $display("FAIL err_beat c%0d got %b/%0d exp 1/0", c, beat_valid, beat_id); end
                checks++; if (done[0] !== (c == 6)) begin errors++; $display("FAIL err_rem c%0d got done0 %b exp %b", c, done[0], c == 6); end
            end
            if (c == 7) begin
                checks++; if (beat_valid !== 1'b0 || err_unreq !== 1'b0) begin errors++; $display("FAIL err_unreq_pre got bv %b unreq %b exp 0/0", beat_valid, err_unreq); end
            end
            if (c == 8) begin
                checks++; if (err_unreq !== 1'b1) begin errors++; $display("FAIL err_unreq got %b exp 1", err_unreq); end
            end
        end
    endtask

    task automatic test_reset_mid_burst();
        arb_mode  = M_P0;
        gnt_force = 4'h0;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        checks++; if (err_onehot !== 1'b0 || err_unreq !== 1'b0) begin errors++; $display("FAIL mid_err_clear got %b%b exp 00", err_onehot, err_unreq); end
        for (int c = 1; c <= 3; c++) begin
            if (c == 1) step(4'b0001, 16'h0003, 4'h0);
            else        step(4'b0000, 16'h0000, 4'h0);
        end
        checks++; if (beat_valid !== 1'b1 || done !== 4'h0) begin errors++; $display("FAIL mid_second_beat got bv %b done %b exp 1/0000", beat_valid, done); end
        #1;
        rst = 1'b1;
        #1;
        checks++; if (req !== 4'h0)       begin errors++; $display("FAIL mid_req got %b exp 0000", req); end
        checks++; if (job_ready !== 4'hF) begin errors++; $display("FAIL mid_job_ready got %b exp 1111", job_ready); end
        checks++; if (done !== 4'h0 || beat_valid !== 1'b0) begin errors++; $display("FAIL mid_done got done %b bv %b exp 0000/0", done, beat_valid); end
        @(posedge clk);
        @(negedge clk);
        checks++; if (done !== 4'h0) begin errors++; $display("FAIL mid_done_hold got %b exp 0000", done); end
        rst = 1'b0;
        for (int c = 1; c <= 3; c++) begin
            if (c == 1) step(4'b0001, 16'h0000, 4'h0);
            else        step(4'b0000, 16'h0000, 4'h0);
            if (c == 1) begin
                checks++; if (req !== 4'b0001) begin errors++; $display("FAIL post_req got %b exp 0001", req); end
            end
            if (c == 2) begin
                checks++; if (done !== 4'b0001 || beat_last !== 1'b1) begin errors++; $display("FAIL post_done got %b/%b exp 0001/1", done, beat_last); end
            end
            if (c == 3) begin
                checks++; if (req !== 4'h0 || job_ready !== 4'hF) begin errors++; $display("FAIL post_idle got req %b rdy %b exp 0000/1111", req, job_ready); end
            end
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        checks    = 0;
        errors    = 0;
        rst       = 1'b1;
        job_valid = '0;
        job_len   = '0;
        gnt_force = '0;
        arb_mode  = M_FORCE;
        test_reset();
        test_p0_burst();
        test_rr_single();
        test_preempt();
        test_starve();
        test_errors();
        test_reset_mid_burst();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
